// File: rtl/accum_sequencer.sv
// accum_sequencer: start-triggered repeat-add controller for the board
// accumulator. The operand and repeat count are captured on a start edge.
// The operand is then added into acc once per clock for that many cycles.
// The controller reports busy, a one-cycle done pulse and a sticky
// overflow flag.
// Optional build macro ACCUM_SEQ_DEBOUNCE_EN puts a DEB_CYCLES-long
// debouncer on the synchronized start level. Clear is never debounced.
module accum_sequencer #(
    parameter int W          = 10,
    parameter int CW         = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    input  logic [W-1:0]  operand,
    input  logic [CW-1:0] count,
    output logic [W-1:0]  acc,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    // Two-stage synchronizers for the asynchronous pushbutton levels.
    logic start_s1_q, start_s2_q;
    logic clear_s1_q, clear_s2_q;

    // Start level after optional debouncing, and its previous sample for edge detection.
    logic start_lvl;
    logic start_prev_q;
    logic start_e;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [W:0]    sum_w;

    // Synchronize start and clear into the CLOCK_50 domain.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            clear_s1_q <= 1'b0;
            clear_s2_q <= 1'b0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            clear_s1_q <= clear;
            clear_s2_q <= clear_s1_q;
        end
    end

`ifdef ACCUM_SEQ_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;

    // Debouncer: the stable level flips only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (start_s2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_d     = start_s2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign start_lvl = deb_q;
`else
    // Without debouncing, the window length has no effect.
    logic deb_cycles_unused;
    assign deb_cycles_unused = (DEB_CYCLES == 0);
    assign start_lvl         = start_s2_q;
`endif

    // Previous start level, so that a held level does not retrigger.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            start_prev_q <= 1'b0;
        end else begin
            start_prev_q <= start_lvl;
        end
    end

    assign start_e = start_lvl & ~start_prev_q;

    // Next-state logic and datapath updates for the sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;
        sum_w   = {1'b0, acc_q} + {1'b0, op_q};
        case (state_q)
            S_IDLE: begin
                // Clear wins over a simultaneous start edge.
                if (clear_s2_q) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end else if (start_e) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                op_d    = operand;
                cnt_d   = count;
                state_d = (count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy  = 1'b1;
                acc_d = sum_w[W-1:0];
                ovf_d = ovf_q | sum_w[W];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Testbench for accum_sequencer: scoreboard of expected per-operation
// results computed arithmetically, checked by a monitor on each done pulse.
// Honours ACCUM_SEQ_DEBOUNCE_EN (DEB_CYCLES is set to 4 here).
module tb_accum_sequencer;

    localparam int W   = 10;
    localparam int CW  = 4;
    localparam int DEB = 4;
`ifdef ACCUM_SEQ_DEBOUNCE_EN
    localparam int LAT    = 3 + DEB;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit DEB_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clear;
    logic [W-1:0]  operand;
    logic [CW-1:0] count;
    logic [W-1:0]  acc;
    logic          busy;
    logic          done;
    logic          ovf;

    always #5 clk = ~clk;

    accum_sequencer #(.W(W), .CW(CW), .DEB_CYCLES(DEB)) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .start   (start),
        .clear   (clear),
        .operand (operand),
        .count   (count),
        .acc     (acc),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    typedef struct {
        int acc;
        int ovf;
        int blen;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   acc_m    = 0;
    int   ovf_m    = 0;
    int   busy_run = 0;
    int   txn      = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: N additions of op equal one addition of op*N; a wrap
    // happened at some step exactly when the unbounded total reaches 2^W.
    task automatic model_op(input int op, input int cnt);
        exp_t e;
        int   total;
        total  = acc_m + op * cnt;
        e.acc  = total % (1 << W);
        e.ovf  = (ovf_m != 0 || total >= (1 << W)) ? 1 : 0;
        e.blen = 1 + cnt;
        exp_q.push_back(e);
        acc_m  = e.acc;
        ovf_m  = e.ovf;
    endtask

    // Monitor: on each done pulse, pop and compare acc, ovf and busy length.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                txn++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: acc=%0d ovf=%0d busy_cycles=%0d (exp acc=%0d ovf=%0d busy=%0d)",
                             txn, acc, ovf, busy_run, e.acc, e.ovf, e.blen);
                    chk("acc", int'(acc), e.acc);
                    chk("ovf", int'(ovf), e.ovf);
                    chk("busy_len", busy_run, e.blen);
                end
                busy_run = 0;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int op, input int cnt, input int hold, input bit disturb);
        int n;
        bit seen;
        operand = W'(op);
        count   = CW'(cnt);
        model_op(op, cnt);
        start = 1'b1;
        n     = 0;
        seen  = 1'b0;
        while (n < 60 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (n >= hold) start = 1'b0;
            if (busy) seen = 1'b1;
        end
        if (!seen) chk("load_timeout", 0, 1);
        else       chk("load_latency", n, LAT);
        while (n < hold) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (disturb) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
            clear = 1'b1;
            repeat (2) @(posedge clk);
            #1 clear = 1'b0;
        end
        wait_idle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        acc_m = 0;
        ovf_m = 0;
        chk("clear_acc", int'(acc), 0);
        chk("clear_ovf", int'(ovf), 0);
    endtask

    initial begin
        int op;
        int cnt;
        int hold;
        int t;
        rst     = 1'b1;
        start   = 1'b0;
        clear   = 1'b0;
        operand = '0;
        count   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_acc", int'(acc), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Directed operations.
        do_op(3, 4, DEB_ON ? 6 : 1, 1'b0);
        do_op(5, 2, DEB_ON ? 6 : 2, 1'b0);
        do_clear();
        do_op(1000, 2, DEB_ON ? 7 : 1, 1'b0);
        do_clear();
        do_op(7, 0, DEB_ON ? 6 : 1, 1'b0);
        do_op(9, 10, DEB_ON ? 6 : 1, 1'b1);

        // Reset asserted mid-RUN aborts with no done pulse.
        operand = W'(50);
        count   = CW'(12);
        start   = 1'b1;
        t = 0;
        while (!busy && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (t >= (DEB_ON ? 6 : 1)) start = 1'b0;
        end
        start = 1'b0;
        chk("midrun_busy_seen", int'(busy), 1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        acc_m = 0;
        ovf_m = 0;
        chk("midrun_reset_acc", int'(acc), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Two-cycle start glitch.
        if (DEB_ON) begin
            operand = W'(4);
            count   = CW'(1);
            start   = 1'b1;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
            t = 0;
            repeat (30) begin
                @(posedge clk); #1;
                if (busy) t++;
            end
            chk("glitch_busy_cycles", t, 0);
            chk("glitch_acc", int'(acc), acc_m);
        end else begin
            do_op(4, 1, 2, 1'b0);
        end
        // Six-cycle press triggers exactly one operation.
        do_op(6, 3, 6, 1'b0);

        // Randomized operations with occasional clears.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) do_clear();
            op   = int'($urandom_range(0, (1 << W) - 1));
            cnt  = int'($urandom_range(0, (1 << CW) - 1));
            hold = DEB_ON ? int'($urandom_range(6, 10)) : int'($urandom_range(1, 8));
            do_op(op, cnt, hold, 1'b0);
        end

        chk("final_acc", int'(acc), acc_m);
        chk("final_ovf", int'(ovf), ovf_m);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Multi-cycle controller for the board-level accumulator datapath: on a pushbutton start event it captures an operand and a repeat count from the switches, then adds the operand into an accumulator register once per clock for the requested number of cycles. It provides busy/done status and sticky overflow. It sits between the synchronized board inputs (KEY, SW) and the LED display in the top-level wrapper. It replaces free-running per-clock accumulation with sequenced, countable operations.

## Interface
Parameters:
- W, 10, accumulator and operand width
- CW, 4, repeat-count width
- DEB_CYCLES, 1000000, debounce stability window in clocks (20 ms at 50 MHz); used only when debounce is compiled in

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  start request, active-high level (top level drives ~KEY[1]); asynchronous to CLOCK_50
- clear  input  1  accumulator clear request, active-high level (top level drives ~KEY[2]); asynchronous
- operand  input  W  value to add each RUN cycle; sampled in LOAD
- count  input  CW  number of additions; sampled in LOAD
- acc  output  W  accumulator value
- busy  output  1  high in LOAD and RUN
- done  output  1  one-cycle pulse in DONE
- ovf  output  1  sticky carry-out flag

## Operation
- start and clear each pass through a 2-FF synchronizer. start_e is the rising edge of the synchronized start, meaning the current sample is 1 and the previous sample is 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if synchronized clear = 1, then acc<=0 and ovf<=0 at the next edge, and any start_e in the same cycle is discarded (clear has priority). Otherwise, start_e moves the FSM to LOAD.
- LOAD: op_r<=operand and cnt_r<=count. If count==0, go to DONE; otherwise go to RUN.
- RUN: each cycle acc<=acc+op_r (mod 2^W), cnt_r<=cnt_r-1, and ovf<=ovf|carry. When cnt_r==1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Accumulation continues from the existing acc value; only clear or reset zeroes it.
- Ignored inputs: start_e and clear in LOAD, RUN or DONE are ignored and not queued. A start level held high does not retrigger; a fresh rising edge is required.
- Reset values: state=IDLE, acc=0, ovf=0, busy=0, done=0, op_r=0, cnt_r=0, synchronizer flops=0.
- Reset asserted mid-operation aborts immediately (asynchronously); no done pulse is produced.

## Timing
- start rising before edge k: LOAD is entered at edge k+2 (2 synchronizer stages plus edge register).
- busy rises with LOAD, stays high for 1+N cycles (N=count), and falls on entry to DONE.
- acc reaches its final value at the edge that enters DONE. done is high for the following cycle; the FSM returns to IDLE one edge later.
- count==0: busy is high 1 cycle (LOAD), then done for 1 cycle, and acc is unchanged.
- Back-to-back operations: the earliest next LOAD is 3 edges after DONE exit, and requires a fresh start edge.
- clear in IDLE: acc and ovf are 0 three edges after the clear input rises.

## Configuration
- ACCUM_SEQ_DEBOUNCE_EN defined: after the synchronizer, the start level passes through a debouncer. The debounced level changes only after the synchronized input has held the new value for DEB_CYCLES consecutive cycles, and start_e is taken from the debounced level. This adds DEB_CYCLES cycles of start latency; clear is not debounced.
- Not defined: start_e is taken directly from the synchronized level, and DEB_CYCLES is unused.

## Test plan
- Reset, then operand=3, count=4, start pulse: busy high for 5 cycles; acc=12; done pulses once; ovf=0.
- Without clear, operand=5, count=2, start: acc=22, ovf=0.
- Clear, then operand=1000, count=2, start: acc=976 (2000 mod 1024), ovf=1. Then clear: acc=0, ovf=0.
- count=0, start: busy high for 1 cycle, done pulses, acc unchanged.
- Second start edge and a clear pulse during RUN are both ignored (acc result as if absent). Reset asserted mid-RUN: acc=0, busy=0, done=0 immediately, no done pulse.
- With ACCUM_SEQ_DEBOUNCE_EN and DEB_CYCLES=4: a 2-cycle start glitch triggers nothing, and a 6-cycle press triggers one operation. Without the macro, the same 2-cycle glitch triggers one operation.
